// File: rtl/psum_readout_address_generator_if.sv
// Bundles the psum readout control, scratchpad read port and output stream.
//   start / max_addr          : launch a readout of addresses 0..max_addr
//   busy / done               : readout in progress / one-cycle completion pulse
//   spad_ren / spad_raddr     : scratchpad read request
//   spad_rdata                : scratchpad read data, one cycle after spad_ren
//   out_valid / out_ready     : output stream handshake
//   out_data / out_last       : output word and last-word tag
//   spad_clr_we/spad_clr_addr : zeroing write port, only with PSUM_CLEAR_ON_READ_EN
// slave is the generator side, master is the surrounding system.
interface psum_readout_address_generator_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] max_addr;
    logic                  busy;
    logic                  done;
    logic                  spad_ren;
    logic [ADDR_WIDTH-1:0] spad_raddr;
    logic [DATA_WIDTH-1:0] spad_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
`ifdef PSUM_CLEAR_ON_READ_EN
    logic                  spad_clr_we;
    logic [ADDR_WIDTH-1:0] spad_clr_addr;

    modport slave (
        input  start, max_addr, spad_rdata, out_ready,
        output busy, done, spad_ren, spad_raddr, out_valid, out_data, out_last,
        output spad_clr_we, spad_clr_addr
    );

    modport master (
        output start, max_addr, spad_rdata, out_ready,
        input  busy, done, spad_ren, spad_raddr, out_valid, out_data, out_last,
        input  spad_clr_we, spad_clr_addr
    );
`else
    modport slave (
        input  start, max_addr, spad_rdata, out_ready,
        output busy, done, spad_ren, spad_raddr, out_valid, out_data, out_last
    );

    modport master (
        output start, max_addr, spad_rdata, out_ready,
        input  busy, done, spad_ren, spad_raddr, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/psum_readout_address_generator.sv
// Psum readout address generator.
// Walks the psum scratchpad from address 0 up to a max address latched at start,
// issues reads to the 1-cycle-latency SRAM and streams the words out on a
// valid/ready interface in ascending address order. A 2-entry buffer absorbs
// backpressure; reads are only issued while a buffer slot is guaranteed.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : psum_readout_address_generator_if.slave (control, SRAM read port,
//          output stream, optional clear port)
// Optional feature macro: PSUM_CLEAR_ON_READ_EN
//   When defined, every word read is zeroed in the scratchpad one cycle after
//   its read via spad_clr_we/spad_clr_addr (write data is zero, driven outside).
module psum_readout_address_generator #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    psum_readout_address_generator_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] max_q;
    logic                  busy_q;
    logic                  done_q;

    // Read issued last cycle whose data is on spad_rdata now.
    logic                  inflight;
    logic                  inflight_last;

    // Two-entry buffer, ent0 is the head.
    entry_t                ent0;
    entry_t                ent1;
    logic                  v0;
    logic                  v1;
    entry_t                ent0_n;
    entry_t                ent1_n;
    logic                  v0_n;
    logic                  v1_n;

    logic [1:0]            occ;
    logic                  ren;
    logic                  at_max;
    logic                  head_valid;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  xfer;
    logic                  pop_buf;
    logic                  push_buf;
    entry_t                push_ent;

    // Words owned by the block: buffered plus the one returning from the SRAM.
    assign occ    = 2'(v0) + 2'(v1) + 2'(inflight);

    // Credit check: only issue when the returning word is sure to find a slot.
    assign ren    = (state == ISSUE) && (occ < 2'd2);

    // Equality compare against the latched max, so max = all-ones never wraps.
    assign at_max = (addr == max_q);

    // With an empty buffer the returning word is presented directly; it is
    // captured into the buffer only if it is not accepted in that cycle.
    assign head_valid = v0 | inflight;
    assign head_data  = v0 ? ent0.data : (inflight ? bus.spad_rdata : '0);
    assign head_last  = v0 ? ent0.last : (inflight & inflight_last);

    assign xfer     = head_valid & bus.out_ready;
    assign pop_buf  = xfer & v0;
    assign push_buf = inflight & ~(xfer & ~v0);
    assign push_ent = '{last: inflight_last, data: bus.spad_rdata};

    // Control FSM, address counter and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            max_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ren;
            inflight_last <= ren & at_max;
            done_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ISSUE;
                        max_q  <= bus.max_addr;
                        addr   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (ren) begin
                        if (at_max) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The max word is the last one issued, so its transfer
                    // leaves the buffer empty with nothing in flight.
                    if (xfer && head_last) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer next state: pop shifts the second entry forward, push fills the
    // first free slot, so a simultaneous pop and push preserves order.
    always_comb begin
        ent0_n = ent0;
        ent1_n = ent1;
        v0_n   = v0;
        v1_n   = v1;
        if (pop_buf) begin
            ent0_n = ent1;
            v0_n   = v1;
            v1_n   = 1'b0;
        end
        if (push_buf) begin
            if (!v0_n) begin
                ent0_n = push_ent;
                v0_n   = 1'b1;
            end else begin
                ent1_n = push_ent;
                v1_n   = 1'b1;
            end
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            v0   <= 1'b0;
            v1   <= 1'b0;
        end else begin
            ent0 <= ent0_n;
            ent1 <= ent1_n;
            v0   <= v0_n;
            v1   <= v1_n;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.spad_ren   = ren;
    assign bus.spad_raddr = addr;
    assign bus.out_valid  = head_valid;
    assign bus.out_data   = head_data;
    assign bus.out_last   = head_last;

`ifdef PSUM_CLEAR_ON_READ_EN
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    // Zero each word the cycle after it was read so the next pass starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_we   <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_we   <= ren;
            clr_addr <= addr;
        end
    end

    assign bus.spad_clr_we   = clr_we;
    assign bus.spad_clr_addr = clr_addr;
`endif

endmodule

// File: tb/tb_psum_readout_address_generator.sv
`timescale 1ns/1ps
module tb_psum_readout_address_generator;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_readout_address_generator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    psum_readout_address_generator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Scratchpad model and the bench's expected contents.
    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          load_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < int'(DEPTH); i++) sram[i] <= ref_mem[i];
        end else begin
            if (bus.spad_ren) bus.spad_rdata <= sram[bus.spad_raddr];
`ifdef PSUM_CLEAR_ON_READ_EN
            if (bus.spad_clr_we) sram[bus.spad_clr_addr] <= '0;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      32'(bus.busy),       0);
        check({tag, "_done"},      32'(bus.done),       0);
        check({tag, "_ren"},       32'(bus.spad_ren),   0);
        check({tag, "_raddr"},     32'(bus.spad_raddr), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid),  0);
        check({tag, "_out_data"},  32'(bus.out_data),   0);
        check({tag, "_out_last"},  32'(bus.out_last),   0);
`ifdef PSUM_CLEAR_ON_READ_EN
        check({tag, "_clr_we"},    32'(bus.spad_clr_we),   0);
        check({tag, "_clr_addr"},  32'(bus.spad_clr_addr), 0);
`endif
    endtask

    // pattern: 0 keep scratchpad, 1 random words, 2 word i = 0x100+i
    task automatic fill_mem(input int pattern);
        if (pattern == 0) return;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (pattern == 1) ref_mem[i] = DW'($urandom);
            else              ref_mem[i] = DW'(32'h100 + i);
        end
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // mode: 0 ready high, 1 ready 1010..., 2 random ready, 3 ready low for 'stall' cycles
    task automatic run_readout(input int max, input int mode, input int stall,
                               input int glitch_max, input int pattern);
        int n, issued, xfers, cyc, first_ren, first_xfer, last_xfer, done_cnt, occ;
        bit xfer, after_done, finished, prev_stall, prev_ren;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [AW-1:0] prev_addr;
        n = max + 1;
        issued = 0; xfers = 0; cyc = 0; done_cnt = 0;
        first_ren = -1; first_xfer = -1; last_xfer = -1;
        after_done = 0; finished = 0; prev_stall = 0; prev_ren = 0;
        prev_data = '0; prev_last = 1'b0; prev_addr = '0;
        fill_mem(pattern);

        bus.max_addr = AW'(max);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (!finished && cyc < 4000) begin
            cyc++;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 2 == 1);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (cyc > stall);
            endcase
            bus.max_addr = AW'($urandom);
            bus.start    = 1'b0;
            if (glitch_max >= 0 && cyc == 2) begin
                bus.start    = 1'b1;
                bus.max_addr = AW'(glitch_max);
            end
            @(negedge clk);

            xfer = bus.out_valid && bus.out_ready;
            if (bus.spad_ren) begin
                occ = issued - xfers;
                check("raddr", 32'(bus.spad_raddr), 32'(issued));
                check("ren_in_range", 32'(issued < n), 1);
                check("credit", 32'(occ < 2), 1);
                if (first_ren < 0) first_ren = cyc;
                issued++;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 1);
                check("hold_data",  32'(bus.out_data),  32'(prev_data));
                check("hold_last",  32'(bus.out_last),  32'(prev_last));
            end
            if (xfer) begin
                if (xfers < n) begin
                    check("data", 32'(bus.out_data), 32'(ref_mem[xfers]));
                    check("last", 32'(bus.out_last), 32'(xfers == max));
                end else begin
                    check("xfer_count", 32'(xfers + 1), 32'(n));
                end
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                xfers++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
`ifdef PSUM_CLEAR_ON_READ_EN
            if (prev_ren) begin
                check("clr_we",   32'(bus.spad_clr_we),   1);
                check("clr_addr", 32'(bus.spad_clr_addr), 32'(prev_addr));
            end else begin
                check("clr_idle", 32'(bus.spad_clr_we), 0);
            end
            prev_ren  = bus.spad_ren;
            prev_addr = bus.spad_raddr;
`endif
            if (mode == 3 && cyc == stall) begin
                check("stall_reads", 32'(issued), 2);
                check("stall_valid", 32'(bus.out_valid), 1);
                check("stall_head",  32'(bus.out_data), 32'(ref_mem[0]));
            end
            if (after_done) begin
                check("busy_after_done", 32'(bus.busy), 0);
                check("done_width",      32'(bus.done), 0);
                finished = 1;
            end else begin
                check("busy", 32'(bus.busy), 1);
                if (bus.done) begin
                    done_cnt++;
                    check("done_words",  32'(xfers), 32'(n));
                    check("done_timing", 32'(cyc), 32'(last_xfer + 1));
                    after_done = 1;
                end
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        check("completed",   32'(finished), 1);
        check("words",       32'(xfers),    32'(n));
        check("reads",       32'(issued),   32'(n));
        check("done_pulses", 32'(done_cnt), 1);
        if (mode == 0) begin
            check("first_ren_latency", 32'(first_ren), 1);
            check("first_out_latency", 32'(first_xfer), 2);
            check("stream_span", 32'(last_xfer - first_ren + 1), 32'(n + 1));
        end
`ifdef PSUM_CLEAR_ON_READ_EN
        for (int i = 0; i <= max; i++) ref_mem[i] = '0;
`endif
    endtask

    // Reset while draining: outputs drop at once, no done, then stay idle.
    task automatic run_abort();
        fill_mem(1);
        bus.out_ready = 1'b1;
        bus.max_addr  = AW'(3);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done",  32'(bus.done),      0);
            check("abort_no_busy",  32'(bus.busy),      0);
            check("abort_no_valid", 32'(bus.out_valid), 0);
            check("abort_no_ren",   32'(bus.spad_ren),  0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.max_addr  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_readout(3,  0, 0,  -1, 2);
        run_readout(0,  0, 0,  -1, 1);
        run_readout(7,  1, 0,  -1, 1);
        run_readout(5,  3, 10, -1, 1);
        run_readout(7,  0, 0,  2,  1);
        run_abort();
        run_readout(4,  0, 0,  -1, 1);
        repeat (6) run_readout(int'($urandom_range(0, 20)), 2, 0, -1, 1);
        run_readout(255, 2, 0, -1, 1);
`ifdef PSUM_CLEAR_ON_READ_EN
        run_readout(2, 0, 0, -1, 1);
        run_readout(2, 0, 0, -1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
